// File: rtl/pudding_loader_pkg.sv
// rtl/pudding_loader_pkg.sv - shared types for the pudding chain loader
package pudding_loader_pkg;

  localparam int CHAIN_LEN_DEF = 128;

  typedef enum logic [3:0] {
    IDLE,
    W_LOAD,
    W_SHIFT,
    W_GAP,
    W_XFER,
    R_XFER,
    R_SAMPLE,
    R_SHIFT,
    R_GAP,
    R_OUT,
    DONE
  } state_t;

  typedef enum logic {
    OP_WRITE = 1'b0,
    OP_READ  = 1'b1
  } op_t;

  typedef enum logic {
    STB_SHIFT = 1'b0,
    STB_XFER  = 1'b1
  } strobe_kind_t;

endpackage

// File: rtl/pudding_strobe_gen.sv
// rtl/pudding_strobe_gen.sv - one-cycle shift/transfer pulse followed by a gap timer
module pudding_strobe_gen
  import pudding_loader_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  strobe_kind_t     kind,
  input  logic             datum,
  input  logic             dir,
  input  logic [DIV_W-1:0] gap,
  output logic             shift_pulse,
  output logic             transfer_pulse,
  output logic             datum_q,
  output logic             dir_q,
  output logic             gap_done
);

  localparam logic [DIV_W-1:0] GAP_ONE = DIV_W'(1);

  logic             active;
  logic [DIV_W-1:0] gap_cnt;

  // gap_done marks the last low cycle so the next start lands back-to-back
  assign gap_done = active && !shift_pulse && !transfer_pulse && (gap_cnt == GAP_ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active         <= 1'b0;
      gap_cnt        <= '0;
      shift_pulse    <= 1'b0;
      transfer_pulse <= 1'b0;
      datum_q        <= 1'b0;
      dir_q          <= 1'b0;
    end else if (start) begin
      active         <= 1'b1;
      gap_cnt        <= (gap == '0) ? GAP_ONE : gap;
      shift_pulse    <= (kind == STB_SHIFT);
      transfer_pulse <= (kind == STB_XFER);
      datum_q        <= datum;
      dir_q          <= dir;
    end else if (shift_pulse || transfer_pulse) begin
      shift_pulse    <= 1'b0;
      transfer_pulse <= 1'b0;
    end else if (active) begin
      if (gap_cnt == GAP_ONE) begin
        active <= 1'b0;
      end else begin
        gap_cnt <= gap_cnt - GAP_ONE;
      end
    end
  end

endmodule

// File: rtl/pudding_chain_loader.sv
// rtl/pudding_chain_loader.sv - byte-stream sequencer for the pudding daisychain/state pair
module pudding_chain_loader
  import pudding_loader_pkg::*;
#(
  parameter int CHAIN_LEN = CHAIN_LEN_DEF,
  parameter int DIV_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_op,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [DIV_W-1:0] div_i,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [7:0]       m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             busy,
  output logic             done,
  output logic             datum_o,
  output logic             shift_o,
  output logic             transfer_o,
  output logic             dir_o,
  output logic             stateen_o,
  input  logic             chain_msb_i
);

  localparam int BIT_W = $clog2(CHAIN_LEN);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CHAIN_LEN - 1);

  state_t           state, next_state;
  logic [BIT_W-1:0] bit_cnt;
  logic [7:0]       byte_q;
  logic [DIV_W-1:0] div_q;

  logic             stb_start;
  strobe_kind_t     stb_kind;
  logic             stb_datum;
  logic             stb_dir;
  logic [DIV_W-1:0] stb_gap;
  logic             gap_done;

  // bit_cnt counts strobes already issued and wraps, so zero after a shift means the chain is full
  logic byte_end;
  logic chain_end;
  assign byte_end  = (bit_cnt[2:0] == 3'd0);
  assign chain_end = (bit_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (cmd_valid) next_state = (op_t'(cmd_op) == OP_READ) ? R_XFER : W_LOAD;
      W_LOAD:   if (s_valid) next_state = W_SHIFT;
      W_SHIFT:  next_state = W_GAP;
      W_GAP: begin
        if (gap_done) begin
          if (chain_end)     next_state = W_XFER;
          else if (byte_end) next_state = W_LOAD;
          else               next_state = W_SHIFT;
        end
      end
      W_XFER:   if (gap_done) next_state = DONE;
      R_XFER:   if (gap_done) next_state = R_SAMPLE;
      R_SAMPLE: next_state = R_SHIFT;
      R_SHIFT:  next_state = R_GAP;
      R_GAP:    if (gap_done) next_state = byte_end ? R_OUT : R_SAMPLE;
      R_OUT:    if (m_ready) next_state = chain_end ? DONE : R_SAMPLE;
      DONE:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    done      = 1'b0;
    stb_start = 1'b0;
    stb_kind  = STB_SHIFT;
    stb_datum = 1'b0;
    stb_dir   = 1'b0;
    stb_gap   = div_q;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        stb_gap   = div_i;
        if (cmd_valid && op_t'(cmd_op) == OP_READ) begin
          stb_start = 1'b1;
          stb_kind  = STB_XFER;
        end
      end
      W_LOAD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          stb_start = 1'b1;
          stb_datum = s_data[0];
          stb_dir   = 1'b1;
        end
      end
      W_GAP: begin
        stb_dir = 1'b1;
        if (gap_done && chain_end) begin
          stb_start = 1'b1;
          stb_kind  = STB_XFER;
        end else if (gap_done && !byte_end) begin
          stb_start = 1'b1;
          stb_datum = byte_q[bit_cnt[2:0]];
        end
      end
      R_SAMPLE: begin
        // recirculate the sampled MSB so the chain ends up where it started
        stb_start = 1'b1;
        stb_datum = chain_msb_i;
      end
      R_OUT:   m_valid = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      byte_q  <= '0;
      div_q   <= '0;
    end else begin
      if (state == IDLE && cmd_valid) begin
        div_q   <= div_i;
        bit_cnt <= '0;
      end
      if (state == W_LOAD && s_valid) byte_q <= s_data;
      if (state == R_SAMPLE) byte_q[bit_cnt[2:0]] <= chain_msb_i;
      if (stb_start && stb_kind == STB_SHIFT)
        bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
    end
  end

  assign m_data    = byte_q;
  assign busy      = (state != IDLE);
  assign stateen_o = busy;

  pudding_strobe_gen #(
    .DIV_W(DIV_W)
  ) u_strobe (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (stb_start),
    .kind          (stb_kind),
    .datum         (stb_datum),
    .dir           (stb_dir),
    .gap           (stb_gap),
    .shift_pulse   (shift_o),
    .transfer_pulse(transfer_o),
    .datum_q       (datum_o),
    .dir_q         (dir_o),
    .gap_done      (gap_done)
  );

endmodule

// File: tb/tb_pudding_chain_loader.sv
// tb/tb_pudding_chain_loader.sv - directed bench with a behavioural pudding chain/state model
module tb_pudding_chain_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_op = 1'b0, cmd_valid = 1'b0, cmd_ready;
  logic [7:0] div_i = 8'd1;
  logic [7:0] s_data = 8'd0;
  logic       s_valid = 1'b0, s_ready;
  logic [7:0] m_data;
  logic       m_valid, m_ready = 1'b0;
  logic       busy, done, datum_o, shift_o, transfer_o, dir_o, stateen_o, chain_msb_i;

  always #5 clk = ~clk;

  pudding_chain_loader #(.CHAIN_LEN(128), .DIV_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_op(cmd_op), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .div_i(div_i), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .busy(busy), .done(done),
    .datum_o(datum_o), .shift_o(shift_o), .transfer_o(transfer_o), .dir_o(dir_o),
    .stateen_o(stateen_o), .chain_msb_i(chain_msb_i)
  );

  // pudding stand-in: chain shifts in at LSB, MSB visible on uo_out[7]
  logic [127:0] chain, pstate;
  logic [7:0]   uo_out, uio_out;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain  <= '0;
      pstate <= '0;
    end else begin
      if (shift_o) chain <= {chain[126:0], datum_o};
      if (transfer_o) begin
        if (dir_o) pstate <= chain;
        else       chain  <= pstate;
      end
    end
  end
  assign chain_msb_i = chain[127];
  assign uo_out      = chain[127:120];
  assign uio_out     = pstate[127:120];

  int checks = 0, failures = 0;
  int shift_cnt = 0, xfer_cnt = 0, done_cnt = 0, both_cnt = 0, hold_shift_cnt = 0;
  int cyc = 0, last_shift = 0, min_gap = 1000, epoch = 0, seen_epoch = 0;
  bit have_last = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (epoch != seen_epoch) begin
      seen_epoch <= epoch;
      min_gap    <= 1000;
      have_last  <= 1'b0;
    end else if (rst_n) begin
      if (shift_o) begin
        shift_cnt <= shift_cnt + 1;
        if (have_last && (cyc - last_shift) < min_gap) min_gap <= cyc - last_shift;
        last_shift <= cyc;
        have_last  <= 1'b1;
      end
      if (transfer_o) xfer_cnt <= xfer_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (shift_o && transfer_o) both_cnt <= both_cnt + 1;
      if (shift_o && m_valid) hold_shift_cnt <= hold_shift_cnt + 1;
    end
  end

  logic [7:0] wbuf [16];
  logic [7:0] ebuf [16];

  function automatic logic [127:0] expect_chain();
    logic [127:0] v;
    for (int n = 0; n < 128; n++) v[127-n] = ebuf[n/8][n%8];
    return v;
  endfunction

  task automatic issue_cmd(input logic op, input logic [7:0] div);
    @(negedge clk);
    cmd_op = op; div_i = div; cmd_valid = 1'b1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++; $display("FAIL cmd_ready_idle got=%b exp=1", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0; div_i = 8'hFF;
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ok);
    int n;
    s_data = b; s_valid = 1'b1; n = 0;
    while (s_ready !== 1'b1 && n < 1500) begin @(negedge clk); n++; end
    ok = (s_ready === 1'b1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL %s_timeout busy=%b exp=0", name, busy);
    end
  endtask

  task automatic run_write(input logic [7:0] div, input int idle_between);
    bit ok, all_ok;
    all_ok = 1'b1;
    issue_cmd(1'b0, div);
    for (int i = 0; i < 16; i++) begin
      send_byte(wbuf[i], ok);
      all_ok &= ok;
      repeat (idle_between) @(negedge clk);
    end
    checks++;
    if (!all_ok) begin failures++; $display("FAIL write_s_ready got=0 exp=1"); end
    wait_idle("write");
  endtask

  task automatic run_read(input logic [7:0] div, input int stall_idx);
    int n, sc;
    logic [7:0] held;
    bit bad;
    issue_cmd(1'b1, div);
    for (int i = 0; i < 16; i++) begin
      n = 0;
      while (m_valid !== 1'b1 && n < 1500) begin @(negedge clk); n++; end
      checks++;
      if (m_valid !== 1'b1) begin
        failures++; $display("FAIL read_m_valid byte=%0d got=%b exp=1", i, m_valid);
        return;
      end
      if (i == stall_idx) begin
        held = m_data; sc = shift_cnt; bad = 1'b0;
        repeat (20) begin
          @(negedge clk);
          if (m_data !== held || m_valid !== 1'b1 || shift_o !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad || shift_cnt != sc) begin
          failures++; $display("FAIL read_hold shifts=%0d exp=%0d m_data=%h exp=%h", shift_cnt, sc, m_data, held);
        end
      end
      checks++;
      if (m_data !== ebuf[i]) begin
        failures++; $display("FAIL read_byte idx=%0d got=%h exp=%h", i, m_data, ebuf[i]);
      end
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
    end
    wait_idle("read");
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({shift_o, transfer_o, datum_o, dir_o, stateen_o, busy, done, m_valid, s_ready, m_data} !== 17'd0) begin
      failures++;
      $display("FAIL %s_outputs shift=%b xfer=%b datum=%b dir=%b stateen=%b busy=%b done=%b m_valid=%b s_ready=%b m_data=%h exp=all0",
               name, shift_o, transfer_o, datum_o, dir_o, stateen_o, busy, done, m_valid, s_ready, m_data);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_basic();
    int s0, x0, d0;
    for (int i = 0; i < 16; i++) begin wbuf[i] = 8'h10 + 8'(i); ebuf[i] = wbuf[i]; end
    s0 = shift_cnt; x0 = xfer_cnt; d0 = done_cnt; epoch++;
    run_write(8'd1, 0);
    checks++;
    if (shift_cnt - s0 != 128) begin failures++; $display("FAIL wr_shift_count got=%0d exp=128", shift_cnt - s0); end
    checks++;
    if (xfer_cnt - x0 != 1) begin failures++; $display("FAIL wr_xfer_count got=%0d exp=1", xfer_cnt - x0); end
    checks++;
    if (done_cnt - d0 != 1) begin failures++; $display("FAIL wr_done_count got=%0d exp=1", done_cnt - d0); end
    checks++;
    if (uio_out !== 8'h08) begin failures++; $display("FAIL wr_uio_out got=%h exp=08", uio_out); end
    checks++;
    if (pstate !== expect_chain()) begin failures++; $display("FAIL wr_state got=%h exp=%h", pstate, expect_chain()); end
    checks++;
    if (min_gap != 2) begin failures++; $display("FAIL wr_spacing_div1 got=%0d exp=2", min_gap); end
  endtask

  task automatic test_read_basic();
    int s0, x0, d0;
    logic [127:0] st0;
    s0 = shift_cnt; x0 = xfer_cnt; d0 = done_cnt; st0 = pstate;
    run_read(8'd1, -1);
    checks++;
    if (uo_out !== 8'h08) begin failures++; $display("FAIL rd_uo_out got=%h exp=08", uo_out); end
    checks++;
    if (chain !== expect_chain() || pstate !== st0) begin
      failures++; $display("FAIL rd_restore chain=%h exp=%h", chain, expect_chain());
    end
    checks++;
    if (shift_cnt - s0 != 128 || xfer_cnt - x0 != 1 || done_cnt - d0 != 1) begin
      failures++; $display("FAIL rd_counts shifts=%0d xfers=%0d dones=%0d exp=128/1/1", shift_cnt - s0, xfer_cnt - x0, done_cnt - d0);
    end
  endtask

  task automatic test_read_backpressure();
    int h0;
    h0 = hold_shift_cnt;
    run_read(8'd2, 3);
    checks++;
    if (hold_shift_cnt != h0) begin failures++; $display("FAIL bp_shift_while_m_valid got=%0d exp=0", hold_shift_cnt - h0); end
  endtask

  task automatic test_write_gaps();
    logic [127:0] st_fast;
    for (int i = 0; i < 16; i++) begin wbuf[i] = 8'h3C ^ (8'(i) * 8'h1D); ebuf[i] = wbuf[i]; end
    epoch++;
    run_write(8'd0, 3);
    st_fast = pstate;
    checks++;
    if (min_gap != 2) begin failures++; $display("FAIL gap_spacing_div0 got=%0d exp=2", min_gap); end
    epoch++;
    run_write(8'd5, 2);
    checks++;
    if (min_gap != 6) begin failures++; $display("FAIL gap_spacing_div5 got=%0d exp=6", min_gap); end
    checks++;
    if (st_fast !== expect_chain() || pstate !== expect_chain()) begin
      failures++; $display("FAIL gap_state div0=%h div5=%h exp=%h", st_fast, pstate, expect_chain());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int d0;
    for (int i = 0; i < 16; i++) wbuf[i] = 8'h5A;
    d0 = done_cnt;
    issue_cmd(1'b0, 8'd3);
    for (int i = 0; i < 7; i++) send_byte(wbuf[i], ok);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (done_cnt != d0) begin failures++; $display("FAIL midreset_done got=%0d exp=0", done_cnt - d0); end
    for (int i = 0; i < 16; i++) begin wbuf[i] = 8'hA5; ebuf[i] = 8'hA5; end
    run_write(8'd1, 0);
    checks++;
    if (pstate !== expect_chain()) begin failures++; $display("FAIL midreset_state got=%h exp=%h", pstate, expect_chain()); end
    run_read(8'd1, -1);
  endtask

  task automatic test_cmd_ignored();
    bit ok;
    int d0, x0;
    for (int i = 0; i < 16; i++) begin wbuf[i] = 8'hC3 - 8'(i); ebuf[i] = wbuf[i]; end
    d0 = done_cnt; x0 = xfer_cnt;
    issue_cmd(1'b0, 8'd1);
    for (int i = 0; i < 16; i++) begin
      send_byte(wbuf[i], ok);
      if (i == 2 || i == 9) begin
        cmd_op = 1'b1; cmd_valid = 1'b1;
        checks++;
        if (cmd_ready !== 1'b0) begin failures++; $display("FAIL busy_cmd_ready got=%b exp=0", cmd_ready); end
        @(negedge clk);
        cmd_valid = 1'b0;
      end
    end
    wait_idle("ignored");
    repeat (4) @(negedge clk);
    checks++;
    if (done_cnt - d0 != 1 || xfer_cnt - x0 != 1) begin
      failures++; $display("FAIL ignored_done dones=%0d xfers=%0d exp=1/1", done_cnt - d0, xfer_cnt - x0);
    end
    checks++;
    if (pstate !== expect_chain()) begin failures++; $display("FAIL ignored_state got=%h exp=%h", pstate, expect_chain()); end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_basic();
    test_read_backpressure();
    test_write_gaps();
    test_reset_mid();
    test_cmd_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog time_limit reached exp=finish");
    $fatal(1);
  end

endmodule
